// File: rtl/scoreboard_pkg.sv
// Shared sizes and default latencies for the amber register scoreboard.
package scoreboard_pkg;

   // Highest bit of the GP/SR target index fields in the instruction word
   localparam int HBIT_TGT_GP = 3;
   localparam int HBIT_TGT_SR = 3;

   localparam int GP_REGS_DEF = 1 << (HBIT_TGT_GP + 1);
   localparam int SR_REGS_DEF = 1 << (HBIT_TGT_SR + 1);

   localparam int LAT_ALU = 1;
   localparam int LAT_MEM = 3;
   localparam int LAT_MAX = 7;

   function automatic int cnt_width(input int lat_max);
      return $clog2(lat_max + 1);
   endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Bank of N countdown counters with two hazard lookups, one max-merge set port
// and a per-register busy vector.
module sb_counter_bank #(
   parameter int N  = 16,
   parameter int CW = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          iw_clk,
   input  logic          iw_rst,
   input  logic          iw_rd_a_en,
   input  logic [IW-1:0] iw_rd_a_idx,
   input  logic          iw_rd_b_en,
   input  logic [IW-1:0] iw_rd_b_idx,
   output logic          ow_hit,
   input  logic          iw_set_en,
   input  logic [IW-1:0] iw_set_idx,
   input  logic [CW-1:0] iw_set_val,
   output logic [N-1:0]  or_busy
);

   logic [CW-1:0] cnt [N];
   logic [CW-1:0] nxt [N];
   logic          hit_a;
   logic          hit_b;

   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      if (iw_rd_a_en && (32'(iw_rd_a_idx) < N))
         hit_a = (cnt[iw_rd_a_idx] != '0);
      if (iw_rd_b_en && (32'(iw_rd_b_idx) < N))
         hit_b = (cnt[iw_rd_b_idx] != '0);
   end

   assign ow_hit = hit_a | hit_b;

   // A new write never shortens an older, longer pending result (WAW)
   always_comb begin
      for (int r = 0; r < N; r++) begin
         nxt[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : '0;
         if (iw_set_en && (iw_set_idx == IW'(r)) && (iw_set_val > nxt[r]))
            nxt[r] = iw_set_val;
      end
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         for (int r = 0; r < N; r++)
            cnt[r] <= '0;
      end else begin
         for (int r = 0; r < N; r++)
            cnt[r] <= nxt[r];
      end
   end

   always_comb begin
      for (int r = 0; r < N; r++)
         or_busy[r] = (cnt[r] != '0);
   end

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard: stalls ID/EX while a read operand is still in flight.
// Optional SR counter bank built when SCOREBOARD_SR_EN is defined.
module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int GP_REGS = GP_REGS_DEF,
   parameter int SR_REGS = SR_REGS_DEF,
   parameter int ALU_LAT = LAT_ALU,
   parameter int MEM_LAT = LAT_MEM,
   parameter int LAT_MX  = LAT_MAX,
   localparam int GPW = $clog2(GP_REGS),
   localparam int SRW = $clog2(SR_REGS)
) (
   input  logic               iw_clk,
   input  logic               iw_rst,
   input  logic               iw_valid,
   input  logic               iw_has_src_gp,
   input  logic [GPW-1:0]     iw_src_gp,
   input  logic               iw_tgt_gp_rd,
   input  logic [GPW-1:0]     iw_tgt_gp,
   input  logic               iw_tgt_gp_we,
   input  logic               iw_has_src_sr,
   input  logic [SRW-1:0]     iw_src_sr,
   input  logic               iw_tgt_sr_rd,
   input  logic [SRW-1:0]     iw_tgt_sr,
   input  logic               iw_tgt_sr_we,
   input  logic               iw_is_load,
   input  logic               iw_flush,
   input  logic               iw_ext_stall,
   output logic               ow_stall,
   output logic               ow_issue,
   output logic [GP_REGS-1:0] or_busy_gp,
   output logic [SR_REGS-1:0] or_busy_sr
);

   localparam int CW = cnt_width(LAT_MX);
   localparam logic [CW-1:0] ALU_SET = CW'(ALU_LAT - 1);
   localparam logic [CW-1:0] MEM_SET = CW'(MEM_LAT - 1);

   if (!((ALU_LAT >= 1) && (ALU_LAT <= MEM_LAT) && (MEM_LAT <= LAT_MX)))
   begin : g_bad_lat
      $error("scoreboard: need 1 <= ALU_LAT <= MEM_LAT <= LAT_MAX");
   end

   logic          gp_hit;
   logic          sr_hit;
   logic          hazard;
   logic [CW-1:0] set_val;

   assign hazard  = gp_hit | sr_hit;
   assign set_val = iw_is_load ? MEM_SET : ALU_SET;

   // Flush and external stall block recording but never the countdown
   assign ow_stall = iw_valid & hazard;
   assign ow_issue = iw_valid & ~hazard & ~iw_flush & ~iw_ext_stall;

   sb_counter_bank #(
      .N  (GP_REGS),
      .CW (CW)
   ) u_gp_bank (
      .iw_clk      (iw_clk),
      .iw_rst      (iw_rst),
      .iw_rd_a_en  (iw_has_src_gp),
      .iw_rd_a_idx (iw_src_gp),
      .iw_rd_b_en  (iw_tgt_gp_rd),
      .iw_rd_b_idx (iw_tgt_gp),
      .ow_hit      (gp_hit),
      .iw_set_en   (ow_issue & iw_tgt_gp_we),
      .iw_set_idx  (iw_tgt_gp),
      .iw_set_val  (set_val),
      .or_busy     (or_busy_gp)
   );

`ifdef SCOREBOARD_SR_EN
   sb_counter_bank #(
      .N  (SR_REGS),
      .CW (CW)
   ) u_sr_bank (
      .iw_clk      (iw_clk),
      .iw_rst      (iw_rst),
      .iw_rd_a_en  (iw_has_src_sr),
      .iw_rd_a_idx (iw_src_sr),
      .iw_rd_b_en  (iw_tgt_sr_rd),
      .iw_rd_b_idx (iw_tgt_sr),
      .ow_hit      (sr_hit),
      .iw_set_en   (ow_issue & iw_tgt_sr_we),
      .iw_set_idx  (iw_tgt_sr),
      .iw_set_val  (set_val),
      .or_busy     (or_busy_sr)
   );
`else
   // SR hazards are resolved downstream by forward
   logic sr_unused;

   assign sr_unused  = ^{iw_has_src_sr, iw_src_sr, iw_tgt_sr_rd,
                         iw_tgt_sr, iw_tgt_sr_we};
   assign sr_hit     = 1'b0;
   assign or_busy_sr = '0;
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Directed test for the register scoreboard.
module tb_scoreboard;

   logic        iw_clk;
   logic        iw_rst;
   logic        iw_valid;
   logic        iw_has_src_gp;
   logic [3:0]  iw_src_gp;
   logic        iw_tgt_gp_rd;
   logic [3:0]  iw_tgt_gp;
   logic        iw_tgt_gp_we;
   logic        iw_has_src_sr;
   logic [3:0]  iw_src_sr;
   logic        iw_tgt_sr_rd;
   logic [3:0]  iw_tgt_sr;
   logic        iw_tgt_sr_we;
   logic        iw_is_load;
   logic        iw_flush;
   logic        iw_ext_stall;
   logic        ow_stall;
   logic        ow_issue;
   logic [15:0] or_busy_gp;
   logic [15:0] or_busy_sr;

   int total = 0;
   int bad = 0;

   scoreboard dut (
      .iw_clk        (iw_clk),
      .iw_rst        (iw_rst),
      .iw_valid      (iw_valid),
      .iw_has_src_gp (iw_has_src_gp),
      .iw_src_gp     (iw_src_gp),
      .iw_tgt_gp_rd  (iw_tgt_gp_rd),
      .iw_tgt_gp     (iw_tgt_gp),
      .iw_tgt_gp_we  (iw_tgt_gp_we),
      .iw_has_src_sr (iw_has_src_sr),
      .iw_src_sr     (iw_src_sr),
      .iw_tgt_sr_rd  (iw_tgt_sr_rd),
      .iw_tgt_sr     (iw_tgt_sr),
      .iw_tgt_sr_we  (iw_tgt_sr_we),
      .iw_is_load    (iw_is_load),
      .iw_flush      (iw_flush),
      .iw_ext_stall  (iw_ext_stall),
      .ow_stall      (ow_stall),
      .ow_issue      (ow_issue),
      .or_busy_gp    (or_busy_gp),
      .or_busy_sr    (or_busy_sr)
   );

   initial iw_clk = 1'b0;
   always #5 iw_clk = ~iw_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic hs, input logic [3:0] s,
                      input logic trd, input logic [3:0] t,
                      input logic we, input logic ld);
      iw_valid      = v;
      iw_has_src_gp = hs;
      iw_src_gp     = s;
      iw_tgt_gp_rd  = trd;
      iw_tgt_gp     = t;
      iw_tgt_gp_we  = we;
      iw_is_load    = ld;
      iw_has_src_sr = 1'b0;
      iw_src_sr     = 4'd0;
      iw_tgt_sr_rd  = 1'b0;
      iw_tgt_sr     = 4'd0;
      iw_tgt_sr_we  = 1'b0;
      iw_flush      = 1'b0;
      iw_ext_stall  = 1'b0;
   endtask

   task automatic step();
      @(posedge iw_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge iw_clk);
   endtask

   initial begin
      iw_rst = 1'b1;
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      #2;
      chk("rst_busy", 32'(or_busy_gp), 32'h0);
      chk("rst_stall", 32'(ow_stall), 32'h0);
      chk("rst_issue", 32'(ow_issue), 32'h1);
      mid();
      iw_rst = 1'b0;
      step();

      // ALU chain r2
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
      mid(); chk("alu_prod_issue", 32'(ow_issue), 32'h1);
      step();
      drv(1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("alu_cons_stall", 32'(ow_stall), 32'h0);
      chk("alu_cons_issue", 32'(ow_issue), 32'h1);
      chk("alu_busy", 32'(or_busy_gp), 32'h0);
      step();

      // load-use r3
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1);
      mid(); chk("ld_prod_issue", 32'(ow_issue), 32'h1);
      step();
      drv(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("ld_t1_stall", 32'(ow_stall), 32'h1);
      chk("ld_t1_issue", 32'(ow_issue), 32'h0);
      chk("ld_t1_busy", 32'(or_busy_gp), 32'h0008);
      step();
      mid(); chk("ld_t2_stall", 32'(ow_stall), 32'h1);
      chk("ld_t2_busy", 32'(or_busy_gp), 32'h0008);
      step();
      mid(); chk("ld_t3_stall", 32'(ow_stall), 32'h0);
      chk("ld_t3_issue", 32'(ow_issue), 32'h1);
      chk("ld_t3_busy", 32'(or_busy_gp), 32'h0);
      step();

      // WAW on r5: load then ALU write, then read via tgt_rd
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
      mid(); chk("waw_ld_issue", 32'(ow_issue), 32'h1);
      step();
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
      mid(); chk("waw_alu_issue", 32'(ow_issue), 32'h1);
      chk("waw_alu_busy", 32'(or_busy_gp), 32'h0020);
      step();
      drv(1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
      mid(); chk("waw_t2_stall", 32'(ow_stall), 32'h1);
      chk("waw_t2_busy", 32'(or_busy_gp), 32'h0020);
      step();
      mid(); chk("waw_t3_stall", 32'(ow_stall), 32'h0);
      chk("waw_t3_issue", 32'(ow_issue), 32'h1);
      step();

      // flush: older load r4 pending, flushed load r7 not recorded
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
      step();
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
      iw_flush = 1'b1;
      mid(); chk("fl_issue", 32'(ow_issue), 32'h0);
      chk("fl_stall", 32'(ow_stall), 32'h0);
      chk("fl_busy0", 32'(or_busy_gp), 32'h0010);
      step();
      drv(1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("fl_busy1", 32'(or_busy_gp), 32'h0010);
      chk("fl_r4_stall", 32'(ow_stall), 32'h1);
      step();
      mid(); chk("fl_r4_issue", 32'(ow_issue), 32'h1);
      chk("fl_busy2", 32'(or_busy_gp), 32'h0);
      step();

      // external stall: no record, countdown continues
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
      iw_ext_stall = 1'b1;
      mid(); chk("ext_issue", 32'(ow_issue), 32'h0);
      step();
      drv(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("ext_norec", 32'(or_busy_gp), 32'h0);
      step();
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1);
      step();
      drv(1'b1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0);
      iw_ext_stall = 1'b1;
      mid(); chk("ext_hz_stall", 32'(ow_stall), 32'h1);
      chk("ext_hz_issue", 32'(ow_issue), 32'h0);
      step();
      drv(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("ext_cnt1", 32'(or_busy_gp), 32'h0040);
      step();
      mid(); chk("ext_cnt0", 32'(or_busy_gp), 32'h0);
      step();

      // SR load-latency write to SR1, then read SR1
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      iw_tgt_sr = 4'd1;
      iw_tgt_sr_we = 1'b1;
      mid(); chk("sr_prod_issue", 32'(ow_issue), 32'h1);
      step();
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      iw_has_src_sr = 1'b1;
      iw_src_sr = 4'd1;
`ifdef SCOREBOARD_SR_EN
      mid(); chk("sr_t1_stall", 32'(ow_stall), 32'h1);
      chk("sr_t1_busy", 32'(or_busy_sr), 32'h0002);
      step();
      mid(); chk("sr_t2_stall", 32'(ow_stall), 32'h1);
      step();
      mid(); chk("sr_t3_issue", 32'(ow_issue), 32'h1);
      step();
`else
      mid(); chk("sr_off_stall", 32'(ow_stall), 32'h0);
      chk("sr_off_issue", 32'(ow_issue), 32'h1);
      chk("sr_off_busy", 32'(or_busy_sr), 32'h0);
      step();
`endif

      // reset mid-countdown
      drv(1'b1, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
      step();
      drv(1'b1, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
      mid(); chk("mr_pre_stall", 32'(ow_stall), 32'h1);
      #1 iw_rst = 1'b1;
      #1;
      chk("mr_stall", 32'(ow_stall), 32'h0);
      chk("mr_busy", 32'(or_busy_gp), 32'h0);
      chk("mr_issue", 32'(ow_issue), 32'h1);
      #1 iw_rst = 1'b0;
      step();
      mid(); chk("mr_after_busy", 32'(or_busy_gp), 32'h0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scoreboard.md
# scoreboard

Parametrised register scoreboard for the in-order amber pipeline; successor to the opcode-only hazard unit. Tracks, per GP (and optionally SR) register, the cycles left until a pending producer's result is forwardable, and stalls the instruction in ID/EX while any operand it reads is still in flight. Supports distinct ALU and load latencies, WAW overlap and branch flush, so `forward` only sees hazards it can resolve.

## Interface
- `GP_REGS`, 16: number of GP registers; index width `GPW = $clog2(GP_REGS)`.
- `SR_REGS`, 16: number of SR registers; index width `SRW = $clog2(SR_REGS)`.
- `ALU_LAT`, 1: producer-to-consumer issue distance for non-load results (1 = back-to-back).
- `MEM_LAT`, 3: issue distance for load results (data available at MO/WB).
- `LAT_MAX`, 7: largest legal latency; counter width `CW = $clog2(LAT_MAX+1)`.
- Ports:
- `iw_clk` in 1: clock.
- `iw_rst` in 1: asynchronous, active-high reset.
- `iw_valid` in 1: instruction present in ID/EX.
- `iw_has_src_gp` in 1, `iw_src_gp` in GPW: first GP operand.
- `iw_tgt_gp_rd` in 1: target GP is also read as an operand.
- `iw_tgt_gp` in GPW, `iw_tgt_gp_we` in 1: GP destination.
- `iw_has_src_sr` in 1, `iw_src_sr` in SRW: SR operand.
- `iw_tgt_sr_rd` in 1, `iw_tgt_sr` in SRW, `iw_tgt_sr_we` in 1: SR destination.
- `iw_is_load` in 1: instruction's result comes from data memory.
- `iw_flush` in 1: branch taken; the ID/EX instruction is killed this cycle.
- `iw_ext_stall` in 1: stall requested by another unit.
- `ow_stall` out 1: operand hazard; freezes IA..ID.
- `ow_issue` out 1: instruction leaves ID/EX this cycle and is recorded.
- `or_busy_gp` out GP_REGS: bit r = GP counter r non-zero (registered).
- `or_busy_sr` out SR_REGS: same for SR.

## Operation
- One countdown counter `cnt[r]` (CW bits) per register; 0 = result forwardable or already written.
- Hazard: `iw_valid` and any read register (src when has_src, tgt when tgt_rd) with `cnt != 0`.
- `ow_stall = iw_valid & hazard`; `ow_issue = iw_valid & ~hazard & ~iw_flush & ~iw_ext_stall`.
- Every cycle each non-zero counter decrements by 1, saturating at 0.
- On `ow_issue` with `tgt_we`: `L = iw_is_load ? MEM_LAT : ALU_LAT`; `cnt[tgt] <= max(cnt[tgt]-1, L-1)`. The max covers WAW, where a shorter-latency write must not hide an older, longer load.
- Flush: the ID/EX instruction is not recorded. Existing counters are untouched because they belong to older, committed-path producers.
- `iw_ext_stall` with no hazard: no issue and no record, but counters keep decrementing.
- Parameter checks at elaboration: `1 <= ALU_LAT <= MEM_LAT <= LAT_MAX`.

## Timing
- Reset (async assert, sync-safe release): all counters 0; `or_busy_*` 0; `ow_stall` 0 and `ow_issue` equals `iw_valid` gated as above.
- `ow_stall` and `ow_issue` are combinational from the inputs and registered counters. There is no path from `iw_*` through to `ow_stall` that feeds back into stage registers.
- A producer issued in cycle t lets a dependent consumer issue no earlier than t+L. With ALU_LAT=1 there is no stall. With MEM_LAT=3 the consumer at t+1 stalls 2 cycles.
- `or_busy_*` reflect counter state after the edge (registered).
- Reset mid-countdown clears all counters immediately; stall drops in the same cycle.

## Configuration
- `SCOREBOARD_SR_EN` defined: an SR counter bank is built and SR operands and targets participate in hazard and issue exactly as GP does.
- Not defined: no SR counters, SR inputs ignored, `or_busy_sr` tied 0, and SR hazards are left to `forward`.

## Structure
- Shared package/header (beside `sizes.vh`): default latencies `LAT_ALU`, `LAT_MEM` and `LAT_MAX`. GP/SR index widths come from the existing `HBIT_TGT_GP`/`HBIT_TGT_SR`.
- Sub-module `sb_counter_bank` (params: N, CW) holds the N countdown counters, two read-lookup ports, one set port with max-merge, and the busy vector. It is instantiated once for GP and once for SR under the macro.

## Test plan
- Reset: assert `iw_rst` mid-run -> `or_busy_gp`=0, `ow_stall`=0 in the same cycle.
- ALU chain: issue write r2 (ALU) at t, read r2 at t+1 -> `ow_stall`=0 and `ow_issue`=1 at t+1.
- Load-use: load r3 at t, read r3 at t+1 -> `ow_stall`=1 at t+1 and t+2, `ow_issue`=1 at t+3.
- WAW: load r5 at t, ALU write r5 at t+1, read r5 at t+2 -> stall until t+3, with `cnt[5]` never dropping below load timing.
- Flush: hazard-free load r7 with `iw_flush`=1 -> `ow_issue`=0 and `or_busy_gp[7]`=0 next cycle; an older pending r4 still counts down.
- SR (macro on): load-latency write to SR1, read SR1 next cycle -> stall 2 cycles. With the macro off -> no stall.
